mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the single unified instruction/data memory between the instruction-fetch requester and the load/store requester of the multi-cycle core. Each access is serialised through one port. The block holds address, write-enable and write-data stable for a fixed memory latency, then captures read data into a register and returns a one-cycle response to the requester that owns the access. When both requesters contend, arbitration is round-robin.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LATENCY, 4, cycles `mem_req` is held per access; legal range 1..15
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high
- i_req  input  1  fetch request; held until accepted
- i_addr  input  ADDR_W  fetch address
- i_ready  output  1  fetch request accepted this cycle
- i_valid  output  1  fetch response, one cycle
- i_rdata  output  DATA_W  fetched word; valid with `i_valid`
- d_req  input  1  data request; held until accepted
- d_we  input  1  1 = store, 0 = load
- d_addr  input  ADDR_W  data address
- d_wdata  input  DATA_W  store data
- d_ready  output  1  data request accepted this cycle
- d_valid  output  1  data response (load data or store ack), one cycle
- d_rdata  output  DATA_W  load data; 0 for a store ack
- mem_req  output  1  memory access active
- mem_we  output  1  memory write enable
- mem_addr  output  ADDR_W  memory address
- mem_wdata  output  DATA_W  memory write data
- mem_rdata  input  DATA_W  memory read data; valid in the last cycle of an access

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - `i_ready = i_req && grant_i`; `d_ready = d_req && grant_d` (combinational).
  - Only d_req: grant D. Only i_req: grant I.
  - Both requesting: grant the side opposite to `last_owner`.
  - On a grant: latch addr, we (0 for I) and wdata; set `owner`; update `last_owner`; load `cnt = MEM_LATENCY-1`; go to ACCESS.
- ACCESS:
  - `mem_req = 1`; mem_* are driven from the latched registers and do not change.
  - `cnt` decrements each cycle.
  - At `cnt == 0`: latch `mem_rdata` into `rdata_q` for a read, or 0 for a write; go to RESP.
- RESP:
  - Owner's `*_valid = 1` for one cycle; `*_rdata = rdata_q`.
  - The other side's valid is 0.
  - Go to IDLE; no grant is issued in RESP.
- `i_rdata`/`d_rdata` are driven from `rdata_q` at all times; only the valid qualifies them.
- A request dropped before acceptance is ignored. Requests during ACCESS/RESP see ready = 0.
- `cnt` width is 4 bits. MEM_LATENCY = 1 gives exactly one ACCESS cycle.

## Timing
- Reset values: state = IDLE, `last_owner` = I (so the first contention goes to D), `cnt` = 0, `rdata_q` = 0, latched fields = 0. All outputs are 0.
- Reset mid-access: the block returns to IDLE immediately (asynchronous). `mem_req` drops, no valid is issued, and the access is abandoned.
- Request accepted at cycle 0: ACCESS spans cycles 1..MEM_LATENCY, RESP at MEM_LATENCY+1, IDLE at MEM_LATENCY+2.
- Request-to-response latency is MEM_LATENCY+1 cycles. Peak throughput is one access per MEM_LATENCY+2 cycles.
- `mem_we` is asserted only while `mem_req = 1` and the owner is D with `d_we = 1` latched.
- At most one of `i_valid`/`d_valid` is high in any cycle. At most one of `i_ready`/`d_ready` is high in any cycle.

## Structure
- Shared package `mem_arb_pkg`: state enum {IDLE, ACCESS, RESP}; owner enum {OWN_I, OWN_D}; default MEM_LATENCY constant.
- Single module; no sub-module. The latency counter and arbiter are small enough to stay inline.

## Test plan
- Fetch only, MEM_LATENCY=4: i_req, i_addr=0x10, mem_rdata=0x00500093 in the last ACCESS cycle. Expect i_ready at cycle 0, mem_req for cycles 1–4 with mem_addr=0x10, i_valid at cycle 5 with i_rdata=0x00500093.
- Store: d_req, d_we=1, d_addr=0x80, d_wdata=0xDEADBEEF. Expect mem_we=1 and mem_wdata=0xDEADBEEF for 4 cycles, then d_valid with d_rdata=0.
- Contention: i_req and d_req held from reset. Expect grants D, I, D, I, i.e. d_ready at cycle 0, i_ready at cycle 6, d_ready at cycle 12.
- Reset mid-access: assert reset in the 2nd ACCESS cycle. Expect mem_req=0 in the same cycle, no valid, and a new i_req accepted on the first cycle after reset releases.
- MEM_LATENCY=1: back-to-back fetches. Expect mem_req for one cycle, valid two cycles after accept, and the next accept three cycles after the previous one.
- Request while busy: d_req raised during ACCESS of a fetch. Expect d_ready=0 until IDLE, then d_ready in the first IDLE cycle.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pkg
// Purpose  : Shared types and defaults for the unified memory port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    localparam int unsigned c_mem_latency_default = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter_if
// Purpose  : Fetch, load/store and memory-side signals of the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_ready;
    logic              i_valid;
    logic [DATA_W-1:0] i_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ready;
    logic              d_valid;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output i_ready, i_valid, i_rdata, d_ready, d_valid, d_rdata,
               mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  i_ready, i_valid, i_rdata, d_ready, d_valid, d_rdata,
               mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Round-robin sharing of one memory port between fetch and
//            load/store, with a fixed-latency access and one-cycle response.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = c_mem_latency_default   // legal range 1..15
) (
    input  wire logic          clk,
    input  wire logic          reset,
    mem_port_arbiter_if.slave  bus
);

    localparam logic [3:0] c_cnt_load = 4'(MEM_LATENCY - 1);

    state_t            r_state;
    owner_t            r_owner;     // also serves as last owner for round-robin
    logic [3:0]        r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic              r_we;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_mem_req;
    logic              r_i_valid;
    logic              r_d_valid;

    logic w_idle;
    logic w_grant_d;
    logic w_grant_i;

    // Contention goes to the side that did not own the previous access.
    assign w_idle    = (r_state == IDLE) && !reset;
    assign w_grant_d = bus.d_req && (!bus.i_req || (r_owner == OWN_I));
    assign w_grant_i = bus.i_req && !w_grant_d;

    assign bus.i_ready   = w_idle && w_grant_i;
    assign bus.d_ready   = w_idle && w_grant_d;
    assign bus.i_valid   = r_i_valid;
    assign bus.d_valid   = r_d_valid;
    assign bus.i_rdata   = r_rdata;
    assign bus.d_rdata   = r_rdata;
    assign bus.mem_req   = r_mem_req;
    assign bus.mem_we    = r_mem_req && r_we;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_owner   <= OWN_I;
            r_cnt     <= 4'd0;
            r_addr    <= '0;
            r_we      <= 1'b0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_mem_req <= 1'b0;
            r_i_valid <= 1'b0;
            r_d_valid <= 1'b0;
        end else begin
            r_i_valid <= 1'b0;
            r_d_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_grant_d || w_grant_i) begin
                        r_owner   <= w_grant_d ? OWN_D : OWN_I;
                        r_addr    <= w_grant_d ? bus.d_addr : bus.i_addr;
                        r_we      <= w_grant_d && bus.d_we;
                        r_wdata   <= w_grant_d ? bus.d_wdata : '0;
                        r_cnt     <= c_cnt_load;
                        r_mem_req <= 1'b1;
                        r_state   <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (r_cnt == 4'd0) begin
                        // Memory data is only guaranteed in the final access cycle.
                        r_rdata   <= r_we ? '0 : bus.mem_rdata;
                        r_mem_req <= 1'b0;
                        r_i_valid <= (r_owner == OWN_I);
                        r_d_valid <= (r_owner == OWN_D);
                        r_state   <= RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Scoreboard bench for mem_port_arbiter at latencies 4 and 1.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int c_l4 = 4;
    localparam int c_l1 = 1;

    typedef struct {
        bit          is_d;
        logic [31:0] rdata;
        int          due;
    } exp_t;

    logic clk;
    logic rst4;
    logic rst1;
    int   cyc;
    int   n_checks;
    int   n_fail;
    exp_t q4[$];
    exp_t q1[$];
    exp_t m4_e;
    exp_t m1_e;
    int   m4_cnt;
    int   m1_cnt;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b4();
    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b1();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(c_l4)) u_dut4 (
        .clk   (clk),
        .reset (rst4),
        .bus   (b4)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(c_l1)) u_dut1 (
        .clk   (clk),
        .reset (rst1),
        .bus   (b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_model(input logic [31:0] addr);
        case (addr)
            32'h10:  return 32'h0050_0093;
            32'h14:  return 32'h00A0_0113;
            32'h20:  return 32'h0020_81B3;
            32'h84:  return 32'hCAFE_F00D;
            32'h200: return 32'h1111_2222;
            default: return 32'h0BAD_F00D;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic push4(input bit is_d, input logic [31:0] rd, input int due);
        exp_t e;
        e.is_d = is_d; e.rdata = rd; e.due = due;
        q4.push_back(e);
    endtask

    task automatic push1(input bit is_d, input logic [31:0] rd, input int due);
        exp_t e;
        e.is_d = is_d; e.rdata = rd; e.due = due;
        q1.push_back(e);
    endtask

    // Memory models: data is only correct in the last cycle of an access.
    always @(negedge clk) begin
        m4_cnt <= b4.mem_req ? m4_cnt + 1 : 0;
        b4.mem_rdata <= (b4.mem_req && (m4_cnt + 1 == c_l4)) ? mem_model(b4.mem_addr)
                                                               : 32'hBAD0_0000 + 32'(m4_cnt);
        m1_cnt <= b1.mem_req ? m1_cnt + 1 : 0;
        b1.mem_rdata <= (b1.mem_req && (m1_cnt + 1 == c_l1)) ? mem_model(b1.mem_addr)
                                                               : 32'hBAD1_0000 + 32'(m1_cnt);
    end

    // Response monitors.
    always @(negedge clk) begin
        if (b4.i_valid || b4.d_valid) begin
            chk("valid4_onehot", 32'(b4.i_valid & b4.d_valid), 32'd0);
            if (q4.size() == 0) begin
                chk("resp4_pending", 32'(q4.size()), 32'd1);
            end else begin
                m4_e = q4.pop_front();
                chk("resp4_side", 32'(b4.d_valid), 32'(m4_e.is_d));
                chk("resp4_data", m4_e.is_d ? b4.d_rdata : b4.i_rdata, m4_e.rdata);
                chk("resp4_cycle", 32'(cyc), 32'(m4_e.due));
            end
        end
        if (b4.i_ready && b4.d_ready) chk("ready4_onehot", 32'd1, 32'd0);
        if (b4.mem_we && !b4.mem_req) chk("we4_qualified", 32'(b4.mem_we), 32'(b4.mem_req));
    end

    always @(negedge clk) begin
        if (b1.i_valid || b1.d_valid) begin
            chk("valid1_onehot", 32'(b1.i_valid & b1.d_valid), 32'd0);
            if (q1.size() == 0) begin
                chk("resp1_pending", 32'(q1.size()), 32'd1);
            end else begin
                m1_e = q1.pop_front();
                chk("resp1_side", 32'(b1.d_valid), 32'(m1_e.is_d));
                chk("resp1_data", m1_e.is_d ? b1.d_rdata : b1.i_rdata, m1_e.rdata);
                chk("resp1_cycle", 32'(cyc), 32'(m1_e.due));
            end
        end
    end

    task automatic wait_ready4(input bit is_d, output bit got, output int acc);
        got = 1'b0;
        acc = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (is_d ? b4.d_ready : b4.i_ready) begin
                got = 1'b1;
                acc = cyc;
                break;
            end
        end
        chk(is_d ? "accept4_d" : "accept4_i", 32'(got), 32'd1);
    endtask

    task automatic drain(input bit use_q4);
        for (int k = 0; k < 40; k++) begin
            if ((use_q4 ? q4.size() : q1.size()) == 0) break;
            @(negedge clk);
        end
        chk(use_q4 ? "drain4" : "drain1", 32'(use_q4 ? q4.size() : q1.size()), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    // One complete access on the latency-4 port, checking the memory window.
    task automatic access4(input bit is_d, input bit we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] exp_rd);
        bit got;
        int acc;
        @(posedge clk); #1;
        if (is_d) begin
            b4.d_req = 1'b1; b4.d_we = we; b4.d_addr = addr; b4.d_wdata = wdata;
        end else begin
            b4.i_req = 1'b1; b4.i_addr = addr;
        end
        wait_ready4(is_d, got, acc);
        if (got) push4(is_d, exp_rd, acc + c_l4 + 1);
        @(posedge clk); #1;
        b4.i_req = 1'b0;
        b4.d_req = 1'b0;
        for (int k = 1; k <= c_l4; k++) begin
            @(negedge clk);
            chk("acc_mem_req", 32'(b4.mem_req), 32'd1);
            chk("acc_mem_addr", b4.mem_addr, addr);
            chk("acc_mem_we", 32'(b4.mem_we), 32'(is_d & we));
            if (is_d && we) chk("acc_mem_wdata", b4.mem_wdata, wdata);
        end
        @(negedge clk);
        chk("acc_mem_req_end", 32'(b4.mem_req), 32'd0);
        drain(1'b1);
    endtask

    initial begin
        bit got;
        int acc;
        n_checks = 0;
        n_fail   = 0;
        rst4 = 1'b1;
        rst1 = 1'b1;
        b4.i_req = 1'b0; b4.i_addr = '0; b4.d_req = 1'b0; b4.d_we = 1'b0;
        b4.d_addr = '0; b4.d_wdata = '0;
        b1.i_req = 1'b0; b1.i_addr = '0; b1.d_req = 1'b0; b1.d_we = 1'b0;
        b1.d_addr = '0; b1.d_wdata = '0;

        // Reset state: every output low.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst4_ctrl", 32'({b4.i_ready, b4.d_ready, b4.i_valid, b4.d_valid,
                              b4.mem_req, b4.mem_we}), 32'd0);
        chk("rst4_addr", b4.mem_addr, 32'd0);
        chk("rst4_wdata", b4.mem_wdata, 32'd0);
        chk("rst4_rdata", b4.i_rdata | b4.d_rdata, 32'd0);
        chk("rst1_ctrl", 32'({b1.i_ready, b1.d_ready, b1.i_valid, b1.d_valid,
                              b1.mem_req, b1.mem_we}), 32'd0);

        // Contention from reset: D, I, D at cycles 0, 6, 12.
        @(posedge clk); #1;
        b4.i_req = 1'b1; b4.i_addr = 32'h200;
        b4.d_req = 1'b1; b4.d_we = 1'b0; b4.d_addr = 32'h84;
        @(negedge clk);
        chk("rst4_ready_gated", 32'({b4.i_ready, b4.d_ready}), 32'd0);
        @(posedge clk); #1;
        rst4 = 1'b0;
        rst1 = 1'b0;
        for (int k = 0; k <= 12; k++) begin
            @(negedge clk);
            chk("cont_d_ready", 32'(b4.d_ready), 32'(k == 0 || k == 12));
            chk("cont_i_ready", 32'(b4.i_ready), 32'(k == 6));
            if (b4.d_ready) push4(1'b1, 32'hCAFE_F00D, cyc + c_l4 + 1);
            if (b4.i_ready) push4(1'b0, 32'h1111_2222, cyc + c_l4 + 1);
        end
        @(posedge clk); #1;
        b4.i_req = 1'b0;
        b4.d_req = 1'b0;
        drain(1'b1);

        // Fetch, store, load.
        access4(1'b0, 1'b0, 32'h10, 32'h0, 32'h0050_0093);
        access4(1'b1, 1'b1, 32'h80, 32'hDEAD_BEEF, 32'h0);
        access4(1'b1, 1'b0, 32'h84, 32'h0, 32'hCAFE_F00D);

        // Data request raised while a fetch is in flight.
        @(posedge clk); #1;
        b4.i_req = 1'b1; b4.i_addr = 32'h10;
        wait_ready4(1'b0, got, acc);
        if (got) push4(1'b0, 32'h0050_0093, acc + c_l4 + 1);
        @(posedge clk); #1;
        b4.i_req = 1'b0;
        b4.d_req = 1'b1; b4.d_we = 1'b0; b4.d_addr = 32'h84;
        for (int k = 1; k <= c_l4 + 2; k++) begin
            @(negedge clk);
            chk("busy_d_ready", 32'(b4.d_ready), 32'(k == c_l4 + 2));
            if (b4.d_ready) push4(1'b1, 32'hCAFE_F00D, cyc + c_l4 + 1);
        end
        @(posedge clk); #1;
        b4.d_req = 1'b0;
        drain(1'b1);

        // Reset in the second access cycle abandons the access.
        @(posedge clk); #1;
        b4.i_req = 1'b1; b4.i_addr = 32'h20;
        wait_ready4(1'b0, got, acc);
        @(posedge clk); #1;
        b4.i_addr = 32'h14;
        @(posedge clk); #1;
        rst4 = 1'b1;
        #1;
        chk("rstmid_mem_req", 32'(b4.mem_req), 32'd0);
        @(negedge clk);
        chk("rstmid_ready", 32'(b4.i_ready), 32'd0);
        @(posedge clk); #1;
        rst4 = 1'b0;
        @(negedge clk);
        chk("rstmid_reaccept", 32'(b4.i_ready), 32'd1);
        if (b4.i_ready) push4(1'b0, 32'h00A0_0113, cyc + c_l4 + 1);
        @(posedge clk); #1;
        b4.i_req = 1'b0;
        drain(1'b1);

        // Latency 1: back-to-back fetches, accepts three cycles apart.
        @(posedge clk); #1;
        b1.i_req = 1'b1; b1.i_addr = 32'h10;
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (b1.i_ready) begin got = 1'b1; acc = cyc; break; end
        end
        chk("b2b_accept0", 32'(got), 32'd1);
        if (got) push1(1'b0, 32'h0050_0093, acc + c_l1 + 1);
        @(posedge clk); #1;
        b1.i_addr = 32'h14;
        @(negedge clk);
        chk("b2b_mem_req", 32'(b1.mem_req), 32'd1);
        chk("b2b_mem_addr", b1.mem_addr, 32'h10);
        @(negedge clk);
        chk("b2b_mem_req_end", 32'(b1.mem_req), 32'd0);
        chk("b2b_no_ready", 32'(b1.i_ready), 32'd0);
        @(negedge clk);
        chk("b2b_accept1", 32'(b1.i_ready), 32'd1);
        if (b1.i_ready) push1(1'b0, 32'h00A0_0113, cyc + c_l1 + 1);
        @(posedge clk); #1;
        b1.i_req = 1'b0;
        drain(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1);
    end

endmodule
`default_nettype wire
